// File: rtl/alu_mul_sequencer.sv
// Shares the EX-stage ALU: combinational pass-through, or a shift-add multiply using ALU add/sub.
// Latency: pass-through 0 cycles; multiply WIDTH+1 cycles (WIDTH+3 with MULSEQ_SIGNED_EN for signed fix-up).
// Backpressure: stall/mul_busy freeze the pipeline while busy; mul_start outside IDLE is dropped.
module alu_mul_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       ex_alucon,
    input  logic [WIDTH-1:0] ex_a,
    input  logic [WIDTH-1:0] ex_b,
    output logic [WIDTH-1:0] ex_result,
    input  logic             mul_start,
    input  logic [WIDTH-1:0] mul_a,
    input  logic [WIDTH-1:0] mul_b,
    input  logic             mul_signed,
    output logic             mul_busy,
    output logic             stall,
    output logic             mul_done,
    output logic [WIDTH-1:0] mul_hi,
    output logic [WIDTH-1:0] mul_lo,
    output logic [3:0]       alu_con,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result
);

    localparam logic [3:0] ALU_ADD = 4'b0010;
`ifdef MULSEQ_SIGNED_EN
    localparam logic [3:0] ALU_SUB = 4'b0011;
    typedef enum logic [2:0] {S_IDLE, S_RUN, S_FIXA, S_FIXB, S_DONE} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_RUN, S_DONE} state_t;
`endif

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_mul_hi;
    logic [WIDTH-1:0] r_mul_lo;
    logic [WIDTH-1:0] w_hi_nxt;
    logic [WIDTH-1:0] w_lo_nxt;
    logic             w_carry;

`ifdef MULSEQ_SIGNED_EN
    logic             r_sa;
    logic             r_sb;
    logic [WIDTH-1:0] r_mul_b;
`else
    logic             w_unused_signed;
    assign w_unused_signed = mul_signed;
`endif

    // The ALU has no carry-out: an unsigned wrap of the sum shows up as result < hi.
    assign w_carry = (alu_result < r_hi);

    always_comb begin
        w_state_nxt = r_state;
        alu_con     = ex_alucon;
        alu_a       = ex_a;
        alu_b       = ex_b;
        w_hi_nxt    = r_hi;
        w_lo_nxt    = r_lo;
        case (r_state)
            S_IDLE: begin
                if (mul_start) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                alu_con  = ALU_ADD;
                alu_a    = r_hi;
                alu_b    = r_lo[0] ? r_mcand : '0;
                w_hi_nxt = {w_carry, alu_result[WIDTH-1:1]};
                w_lo_nxt = {alu_result[0], r_lo[WIDTH-1:1]};
                if (r_cnt == CNT_W'(WIDTH-1)) begin
`ifdef MULSEQ_SIGNED_EN
                    w_state_nxt = S_FIXA;
`else
                    w_state_nxt = S_DONE;
`endif
                end
            end
`ifdef MULSEQ_SIGNED_EN
            S_FIXA: begin
                alu_con     = ALU_SUB;
                alu_a       = r_hi;
                alu_b       = r_sa ? r_mul_b : '0;
                w_hi_nxt    = alu_result;
                w_state_nxt = S_FIXB;
            end
            S_FIXB: begin
                alu_con     = ALU_SUB;
                alu_a       = r_hi;
                alu_b       = r_sb ? r_mcand : '0;
                w_hi_nxt    = alu_result;
                w_state_nxt = S_DONE;
            end
`endif
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_mcand  <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_cnt    <= '0;
            r_mul_hi <= '0;
            r_mul_lo <= '0;
`ifdef MULSEQ_SIGNED_EN
            r_sa     <= 1'b0;
            r_sb     <= 1'b0;
            r_mul_b  <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (mul_start) begin
                        r_mcand <= mul_a;
                        r_lo    <= mul_b;
                        r_hi    <= '0;
                        r_cnt   <= '0;
`ifdef MULSEQ_SIGNED_EN
                        r_sa    <= mul_signed & mul_a[WIDTH-1];
                        r_sb    <= mul_signed & mul_b[WIDTH-1];
                        r_mul_b <= mul_b;
`endif
                    end
                end
                S_RUN: begin
                    r_hi  <= w_hi_nxt;
                    r_lo  <= w_lo_nxt;
                    r_cnt <= r_cnt + 1'b1;
                end
`ifdef MULSEQ_SIGNED_EN
                S_FIXA, S_FIXB: r_hi <= w_hi_nxt;
`endif
                default: ;
            endcase
            // Publish the product on entry to DONE so it is valid alongside mul_done.
            if (w_state_nxt == S_DONE) begin
                r_mul_hi <= w_hi_nxt;
                r_mul_lo <= w_lo_nxt;
            end
        end
    end

    assign ex_result = alu_result;
    assign mul_busy  = (r_state != S_IDLE);
    assign stall     = mul_busy;
    assign mul_done  = (r_state == S_DONE);
    assign mul_hi    = r_mul_hi;
    assign mul_lo    = r_mul_lo;

endmodule
